// File: rtl/debounce_pkg.sv
// Shared defaults and types for the debounce_bank push-button debouncer.
// Optional auto-repeat is compiled in by defining DEBOUNCE_REPEAT_EN.
package debounce_pkg;

    // Default widths: stability window 2^16, long press ~2^24, repeat 2^22.
    localparam int DEB_CNT_W_DEF  = 16;
    localparam int DEB_HOLD_W_DEF = 24;
    localparam int DEB_REP_W_DEF  = 22;

    // Per-channel one-cycle event bundle.
    typedef struct packed {
        logic down;
        logic up;
        logic long_p;
        logic rpt;
    } deb_strobe_t;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: two-flop synchroniser, stability counter, long-press
// hold timer and (with DEBOUNCE_REPEAT_EN) an auto-repeat period counter.
// Every output is decoded from registered state only; nothing is
// combinational from the raw pin.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int CNT_W      = DEB_CNT_W_DEF,
    parameter int HOLD_W     = DEB_HOLD_W_DEF,
    parameter int REP_W      = DEB_REP_W_DEF,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pb,
    output logic state,
    output logic down,
    output logic up,
    output logic long_p,
    output logic rpt
);

    logic              sync0;
    logic              sync1;
    logic              state_q;
    logic [CNT_W-1:0]  cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_flag;

    logic idle;
    logic cnt_max;
    logic accept;
    logic long_hit;
    logic long_nxt;

    // Debounced level equals the synchronised input: nothing to filter.
    assign idle    = (state_q == sync1);
    assign cnt_max = &cnt;
    // Input has disagreed with the debounced level for the full window.
    assign accept  = ~idle & cnt_max;

    // Long press fires once, the cycle the hold timer reaches all-ones.
    assign long_hit = state_q & ~long_flag & (&hold_cnt);
    // long_flag as it will be after this edge; drops with the debounced level.
    assign long_nxt = state_q & (long_flag | long_hit);

    assign state  = state_q;
    assign down   = accept & ~state_q;
    assign up     = accept &  state_q;
    assign long_p = long_hit;

    // Two-flop synchroniser, polarity normalised so 1 always means pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= pb ^ ACTIVE_LOW;
            sync1 <= sync0;
        end
    end

    // Stability counter: any return to equality restarts the window; the
    // level flips when the window completes, which also restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            state_q <= 1'b0;
        end else if (idle) begin
            cnt <= '0;
        end else if (accept) begin
            cnt     <= '0;
            state_q <= ~state_q;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Hold timer: counts while pressed until the long press is reported,
    // then parks so it can never wrap and fire a second time.
    always_ff @(posedge clk) begin
        if (rst || !state_q) begin
            hold_cnt <= '0;
        end else if (!long_flag && !long_hit) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Long-press flag: set by the long strobe, cleared on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            long_flag <= 1'b0;
        end else begin
            long_flag <= long_nxt;
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    logic [REP_W-1:0] rep_cnt;

    // Repeat counter starts on the long-press edge so the first repeat lands
    // 2^REP_W-1 cycles after PB_long, then free-wraps for a 2^REP_W period.
    always_ff @(posedge clk) begin
        if (rst || !long_nxt) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

    // Gated by the level so repeats stop in the very cycle the level falls.
    assign rpt = long_flag & state_q & (&rep_cnt);
`else
    assign rpt = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: CHANNELS independent push-button debouncers with press,
// release, long-press and optional auto-repeat strobes (DEBOUNCE_REPEAT_EN).
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS   = 8,
    parameter int CNT_W      = DEB_CNT_W_DEF,
    parameter int HOLD_W     = DEB_HOLD_W_DEF,
    parameter int REP_W      = DEB_REP_W_DEF,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] PB,
    output logic [CHANNELS-1:0] PB_state,
    output logic [CHANNELS-1:0] PB_down,
    output logic [CHANNELS-1:0] PB_up,
    output logic [CHANNELS-1:0] PB_long,
    output logic [CHANNELS-1:0] PB_repeat,
    output logic                PB_any
);

    deb_strobe_t [CHANNELS-1:0] strobe;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        debounce_chan #(
            .CNT_W      (CNT_W),
            .HOLD_W     (HOLD_W),
            .REP_W      (REP_W),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .pb     (PB[g]),
            .state  (PB_state[g]),
            .down   (strobe[g].down),
            .up     (strobe[g].up),
            .long_p (strobe[g].long_p),
            .rpt    (strobe[g].rpt)
        );

        assign PB_down[g]   = strobe[g].down;
        assign PB_up[g]     = strobe[g].up;
        assign PB_long[g]   = strobe[g].long_p;
        assign PB_repeat[g] = strobe[g].rpt;
    end

    assign PB_any = |PB_state;

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank (2 channels, short widths).
// Repeat expectations follow DEBOUNCE_REPEAT_EN when it is defined.
module tb_debounce_bank;

    localparam int  CH     = 2;
    localparam int  CNT_W  = 4;
    localparam int  HOLD_W = 5;
    localparam int  REP_W  = 3;
    localparam bit  AL     = 1'b1;
    localparam int  ACC    = 1 << CNT_W;
    localparam int  HOLD   = 1 << HOLD_W;
    localparam int  REP    = 1 << REP_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] PB  = '1;
    logic [CH-1:0] PB_state, PB_down, PB_up, PB_long, PB_repeat;
    logic          PB_any;

    debounce_bank #(
        .CHANNELS(CH), .CNT_W(CNT_W), .HOLD_W(HOLD_W), .REP_W(REP_W), .ACTIVE_LOW(AL)
    ) dut (
        .clk(clk), .rst(rst), .PB(PB),
        .PB_state(PB_state), .PB_down(PB_down), .PB_up(PB_up),
        .PB_long(PB_long), .PB_repeat(PB_repeat), .PB_any(PB_any)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [CH-1:0] o_state, o_down, o_up, o_long, o_rep;
    logic          o_any;

    // Reference model: level accepted after ACC consecutive disagreeing
    // cycles; long/repeat derived from the timestamp of the press.
    bit m_s0[CH], m_s1[CH], m_st[CH];
    int m_run[CH], m_rise[CH];
    int m_t = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [CH-1:0] p);
        bit tog;
        m_t++;
        for (int c = 0; c < CH; c++) begin
            if (r) begin
                m_s0[c] = 0; m_s1[c] = 0; m_st[c] = 0; m_run[c] = 0;
            end else begin
                tog = (m_run[c] == ACC);
                if (tog) begin
                    m_st[c] = !m_st[c];
                    if (m_st[c]) m_rise[c] = m_t;
                end
                m_s1[c] = m_s0[c];
                m_s0[c] = p[c] ^ AL;
                if (m_s1[c] != m_st[c]) m_run[c] = tog ? 1 : m_run[c] + 1;
                else m_run[c] = 0;
            end
        end
    endtask

    task automatic model_out(output logic [5*CH:0] e);
        logic [CH-1:0] st, dn, up, lg, rp;
        int k;
        for (int c = 0; c < CH; c++) begin
            st[c] = m_st[c];
            dn[c] = (m_run[c] == ACC) && !m_st[c];
            up[c] = (m_run[c] == ACC) &&  m_st[c];
            lg[c] = m_st[c] && (m_t - m_rise[c] == HOLD - 1);
            k = m_t - m_rise[c] - (HOLD - 1) - (REP - 1);
`ifdef DEBOUNCE_REPEAT_EN
            rp[c] = m_st[c] && (k >= 0) && ((k % REP) == 0);
`else
            rp[c] = 1'b0;
`endif
        end
        e = {st, dn, up, lg, rp, |st};
    endtask

    // One clock: drive, clock edge, advance model, sample on falling edge.
    task automatic step(input logic r, input logic [CH-1:0] p);
        logic [5*CH:0] e;
        rst = r;
        PB  = p;
        @(posedge clk);
        model_edge(r, p);
        @(negedge clk);
        cyc++;
        o_state = PB_state; o_down = PB_down; o_up = PB_up;
        o_long = PB_long; o_rep = PB_repeat; o_any = PB_any;
        model_out(e);
        chk("model", 32'({o_state, o_down, o_up, o_long, o_rep, o_any}), 32'(e));
    endtask

    typedef struct {
        logic          r;
        logic [CH-1:0] pb;
        int            n;
        logic [CH-1:0] st, dn, up;
        logic          any;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int c0, c1, c2, nd, nu, nl, nr, last_rep, bad_gap, rep_fall;

        tbl[0]  = '{1'b1, 2'b11,  3, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[1]  = '{1'b0, 2'b11,  5, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[2]  = '{1'b0, 2'b10, 16, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[3]  = '{1'b0, 2'b10,  1, 2'b00, 2'b01, 2'b00, 1'b0};
        tbl[4]  = '{1'b0, 2'b10,  1, 2'b01, 2'b00, 2'b00, 1'b1};
        tbl[5]  = '{1'b0, 2'b10, 10, 2'b01, 2'b00, 2'b00, 1'b1};
        tbl[6]  = '{1'b0, 2'b11, 16, 2'b01, 2'b00, 2'b00, 1'b1};
        tbl[7]  = '{1'b0, 2'b11,  1, 2'b01, 2'b00, 2'b01, 1'b1};
        tbl[8]  = '{1'b0, 2'b11,  1, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[9]  = '{1'b0, 2'b00, 17, 2'b00, 2'b11, 2'b00, 1'b0};
        tbl[10] = '{1'b0, 2'b00,  1, 2'b11, 2'b00, 2'b00, 1'b1};
        tbl[11] = '{1'b1, 2'b00,  1, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[12] = '{1'b0, 2'b00, 16, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[13] = '{1'b0, 2'b00,  1, 2'b00, 2'b11, 2'b00, 1'b0};

        // Table vectors: hold each input n cycles, check on the last one.
        for (int i = 0; i < 14; i++) begin
            for (int j = 0; j < tbl[i].n; j++) step(tbl[i].r, tbl[i].pb);
            chk($sformatf("vec%0d", i), 32'({o_state, o_down, o_up, o_any}),
                32'({tbl[i].st, tbl[i].dn, tbl[i].up, tbl[i].any}));
        end

        // Bounce: low 10, high 3, then steady low; one press 17 cycles on.
        step(1, 2'b11); step(1, 2'b11);
        repeat (3) step(0, 2'b11);
        repeat (10) step(0, 2'b10);
        repeat (3) step(0, 2'b11);
        nd = 0; c1 = -1; c0 = cyc + 1;
        for (int i = 0; i < 40; i++) begin
            step(0, 2'b10);
            if (o_down[0]) begin nd++; if (c1 < 0) c1 = cyc; end
        end
        chk("bounce_down_count", 32'(nd), 32'd1);
        chk("bounce_down_delay", 32'(c1 - c0 + 1), 32'd17);

        // Long press and auto-repeat, then release.
        step(1, 2'b11);
        repeat (3) step(0, 2'b11);
        c0 = -1; c1 = -1; c2 = -1; nl = 0; nr = 0; last_rep = -1; bad_gap = 0;
        for (int i = 0; i < 100; i++) begin
            step(0, 2'b10);
            if (o_state[0] && c0 < 0) c0 = cyc;
            if (o_long[0]) begin nl++; c1 = cyc; end
            if (o_rep[0]) begin
                nr++;
                if (c2 < 0) c2 = cyc;
                else if (cyc - last_rep != REP) bad_gap++;
                last_rep = cyc;
            end
        end
        chk("long_count", 32'(nl), 32'd1);
        chk("long_delay", 32'(c1 - c0), 32'(HOLD - 1));
        chk("long_ch1_idle", 32'(o_state[1]), 32'd0);
`ifdef DEBOUNCE_REPEAT_EN
        chk("repeat_first", 32'(c2 - c1), 32'(REP - 1));
        chk("repeat_gaps", 32'(bad_gap), 32'd0);
        chk("repeat_some", 32'(nr >= 3), 32'd1);
`else
        chk("repeat_absent", 32'(nr), 32'd0);
`endif
        nu = 0; nl = 0; rep_fall = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 2'b11);
            if (o_up[0]) nu++;
            if (o_long[0]) nl++;
            if (o_rep[0] && !o_state[0]) rep_fall++;
        end
        chk("release_up_count", 32'(nu), 32'd1);
        chk("release_no_long", 32'(nl), 32'd0);
        chk("release_no_repeat", 32'(rep_fall), 32'd0);

        // Reset mid-count discards progress; a full window restarts.
        step(1, 2'b11);
        repeat (3) step(0, 2'b11);
        repeat (12) step(0, 2'b10);
        step(1, 2'b10);
        chk("rst_mid_outputs", 32'({o_state, o_down, o_up, o_long, o_rep, o_any}), 32'd0);
        c0 = -1; nd = 0;
        for (int i = 0; i < 25; i++) begin
            step(0, 2'b10);
            if (o_down[0]) begin nd++; if (c0 < 0) c0 = i + 1; end
        end
        chk("rst_restart_delay", 32'(c0), 32'd17);
        chk("rst_restart_count", 32'(nd), 32'd1);

        // Randomised bouncing and holds against the reference model.
        begin
            logic [CH-1:0] lvl;
            int            left[CH];
            lvl = '1;
            for (int c = 0; c < CH; c++) left[c] = 0;
            for (int i = 0; i < 4000; i++) begin
                for (int c = 0; c < CH; c++) begin
                    if (left[c] == 0) begin
                        lvl[c]  = ~lvl[c];
                        left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 110)
                                                             : $urandom_range(1, 20);
                    end
                    left[c]--;
                end
                step($urandom_range(0, 799) == 0, lvl);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
